// File: rtl/vic_regbank_pkg.sv
// Shared types and default geometry for the VIC register bank.
package vic_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;
endpackage

// File: rtl/vic_regbank_if.sv
// Register access bus of the VIC register bank.
interface vic_regbank_if
  import vic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [ADDR_W-1:0] i_VIC_regaddr;
  logic [DATA_W-1:0] i_VIC_data;
  logic              i_VIC_we;
  logic              i_VIC_re;
  logic [DATA_W-1:0] o_VIC_data;
  logic              o_VIC_rvalid;

  // There is no ready: every re/we is sampled on its rising edge; a read
  // answers with a single-cycle o_VIC_rvalid one edge later, and o_VIC_data
  // keeps its last value while rvalid is low.
  modport master (
    output i_VIC_regaddr, i_VIC_data, i_VIC_we, i_VIC_re,
    input  o_VIC_data, o_VIC_rvalid
  );
  modport slave (
    input  i_VIC_regaddr, i_VIC_data, i_VIC_we, i_VIC_re,
    output o_VIC_data, o_VIC_rvalid
  );
endinterface

// File: rtl/vic_regbank_clr.sv
// Clear sequencer: walks idx from 0 to NREGS-1, one register per cycle.
module vic_regbank_clr
  import vic_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] idx,
  output logic              step,
  output clr_state_t        state
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Explicit return to 0 at LAST_IDX keeps non-power-of-two banks in range.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == CLEAR);
  assign idx   = idx_q;
  assign state = state_q;
endmodule

// File: rtl/vic_regbank.sv
// VIC register bank; define VIC_REGBANK_SHADOW_EN for a shadow bank that is
// copied to the active bank (o_buffer) on i_commit, otherwise a single bank.
module vic_regbank
  import vic_pkg::*;
#(
  parameter int                      DATA_W  = DEF_DATA_W,
  parameter int                      NREGS   = DEF_NREGS,
  parameter int                      ADDR_W  = DEF_ADDR_W,
  parameter logic [NREGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  vic_regbank_if.slave            bus,
  input  logic                    i_commit,
  input  logic                    i_clear,
  output logic                    o_busy,
  output logic                    o_pending,
  output logic [NREGS*DATA_W-1:0] o_buffer
);
  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

  logic [DATA_W-1:0] shadow [NREGS];
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_step;
  logic              busy;
  clr_state_t        clr_state;
  logic              addr_ok, wr_acc, clr_start;

  vic_regbank_clr #(.NREGS(NREGS), .ADDR_W(ADDR_W)) u_clr (
    .clk   (clk),
    .rst   (rst),
    .start (i_clear),
    .busy  (busy),
    .idx   (clr_idx),
    .step  (clr_step),
    .state (clr_state)
  );

  assign addr_ok   = ({1'b0, bus.i_VIC_regaddr} < NREGS_W);
  assign wr_acc    = bus.i_VIC_we & ~busy & addr_ok;
  assign clr_start = i_clear & (clr_state == IDLE);
  assign o_busy    = busy;

  // Out-of-range addresses match no register and read back as zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NREGS; k++)
      if (bus.i_VIC_regaddr == ADDR_W'(k)) rd_word = shadow[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) shadow[k] <= RST_VAL[k*DATA_W +: DATA_W];
      bus.o_VIC_data   <= '0;
      bus.o_VIC_rvalid <= 1'b0;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (wr_acc && bus.i_VIC_regaddr == ADDR_W'(k))
          shadow[k] <= bus.i_VIC_data;
        else if (clr_step && clr_idx == ADDR_W'(k))
          shadow[k] <= RST_VAL[k*DATA_W +: DATA_W];
      end
      bus.o_VIC_rvalid <= bus.i_VIC_re;
      if (bus.i_VIC_re) bus.o_VIC_data <= rd_word;
    end
  end

`ifdef VIC_REGBANK_SHADOW_EN
  logic [DATA_W-1:0] active [NREGS];
  logic              commit_acc;

  assign commit_acc = i_commit & ~busy;

  // A write landing on the commit edge is merged into the copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) active[k] <= RST_VAL[k*DATA_W +: DATA_W];
      o_pending <= 1'b0;
    end else begin
      if (commit_acc)
        for (int k = 0; k < NREGS; k++)
          active[k] <= (wr_acc && bus.i_VIC_regaddr == ADDR_W'(k)) ? bus.i_VIC_data : shadow[k];
      if (clr_start)       o_pending <= 1'b1;
      else if (commit_acc) o_pending <= 1'b0;
      else if (wr_acc)     o_pending <= 1'b1;
    end
  end

  always_comb begin
    o_buffer = '0;
    for (int k = 0; k < NREGS; k++) o_buffer[k*DATA_W +: DATA_W] = active[k];
  end
`else
  logic unused_commit;
  assign unused_commit = i_commit;
  assign o_pending     = 1'b0;

  always_comb begin
    o_buffer = '0;
    for (int k = 0; k < NREGS; k++) o_buffer[k*DATA_W +: DATA_W] = shadow[k];
  end
`endif
endmodule

// File: doc/vic_regbank.md
VIC_REGBANK -- requirements
Module: vic_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 4, bits per register.
REQ-002 SHALL have parameter NREGS, default 32, number of registers (2..256).
REQ-003 SHALL have parameter ADDR_W, default 5, register address width; NREGS <= 2**ADDR_W.
REQ-004 SHALL have parameter RST_VAL, default all-zero, NREGS*DATA_W flat vector of per-register reset values, register k in bits [k*DATA_W +: DATA_W].
REQ-005 One clock; reset is synchronous and active-high. Ports: clk, then rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 i_VIC_regaddr  input  ADDR_W  register index for read/write.
REQ-009 i_VIC_data  input  DATA_W  write data.
REQ-010 i_VIC_we  input  1  write enable, sampled each rising edge.
REQ-011 i_VIC_re  input  1  read request, sampled each rising edge.
REQ-012 o_VIC_data  output  DATA_W  registered read data.
REQ-013 o_VIC_rvalid  output  1  one-cycle pulse qualifying o_VIC_data.
REQ-014 i_commit  input  1  copy shadow bank to active bank (frame/vblank strobe).
REQ-015 i_clear  input  1  start sequential restore of shadow bank to RST_VAL.
REQ-016 o_busy  output  1  clear sequence in progress.
REQ-017 o_pending  output  1  shadow bank modified since last commit.
REQ-018 o_buffer  output  NREGS*DATA_W  active bank, flat, same packing as RST_VAL.

Function
REQ-019 Write accepted when we=1, busy=0, addr<NREGS: shadow[addr] <= i_VIC_data at that edge; otherwise dropped, no side effects.
REQ-020 Read: re=1 at edge N -> o_VIC_data = shadow[addr] as before edge N, rvalid=1 after edge N; rvalid=0 otherwise; o_VIC_data holds last value when rvalid=0.
REQ-021 Read of addr>=NREGS SHALL return 0 with rvalid=1; reads are permitted while busy.
REQ-022 we and re same cycle, same addr: read returns pre-write value.
REQ-023 Commit when i_commit=1, busy=0: active <= shadow including any write accepted at the same edge; o_buffer reflects it the cycle after; commit while busy ignored.
REQ-024 o_pending set by any accepted write or by clear start; cleared by a commit (same-edge write+commit leaves pending=0).
REQ-025 Clear FSM states IDLE, CLEAR; IDLE->CLEAR on i_clear=1 (index counter <= 0, busy=1); i_clear while CLEAR ignored.
REQ-026 In CLEAR each cycle shadow[idx] <= RST_VAL[idx], idx++; after idx=NREGS-1 -> IDLE; busy high exactly NREGS cycles; active bank untouched.
REQ-027 Index counter SHALL not wrap past NREGS-1 for non-power-of-two NREGS.

Reset
REQ-028 On rst=1 at an edge: shadow and active <= RST_VAL, o_VIC_data=0, rvalid=0, busy=0, pending=0, FSM=IDLE, counter=0; rst overrides all inputs and aborts a clear in progress.

Configuration
REQ-029 Macro VIC_REGBANK_SHADOW_EN defined: behaviour as REQ-019..REQ-027.
REQ-030 Macro undefined: single bank; accepted writes and clear steps update o_buffer directly (visible next cycle), i_commit ignored, o_pending tied 0, reads return that bank.

Structure
REQ-031 Shared package vic_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and default DATA_W/NREGS/ADDR_W constants.
REQ-032 Clear sequencer SHALL be sub-module vic_regbank_clr (FSM + index counter, outputs busy, idx, step strobe); storage stays in vic_regbank.

Verification
REQ-033 Reset, then read all 32 regs with RST_VAL=0 -> 32 rvalid pulses, data 0, o_buffer=0.
REQ-034 Write reg 3=0xA, no commit -> read reg 3 returns 0xA, o_buffer[15:12]=0, pending=1; then commit -> o_buffer[15:12]=0xA, pending=0.
REQ-035 Same edge we+re reg 7 data 0x5 (prior 0x2) -> read returns 0x2; next read returns 0x5.
REQ-036 Same edge write reg 0=0xF and commit -> o_buffer[3:0]=0xF next cycle, pending=0.
REQ-037 Pulse i_clear -> busy high 32 cycles; writes and commits during busy dropped; afterwards shadow=RST_VAL, pending=1.
REQ-038 Assert rst at clear index 10 -> busy=0 next cycle, all regs=RST_VAL; write to addr 31 with NREGS=20 -> dropped, read returns 0.
